phase_timer: RTL

- Consumer end of the time-select interface: takes the 19-bit interval that the time selector drives for the current controller state, counts it down, and reports expiry back to the train-controller FSM.
- It is the timer the main FSM waits on to leave timed states (states 4'b0010..4'b0101).
- Sits between the time selector and the next-state logic; one instance per controller.

---
 rtl/phase_timer_if.sv | 35 +++
 rtl/phase_timer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/phase_timer_if.sv
// Time-select interface between the controller (master) and phase_timer (slave).
// PHASE_TIMER_PAUSE_EN adds the pause request to the bundle.
interface phase_timer_if #(
  parameter int TW = 19
);
  logic [3:0]    present_state;
  logic [TW-1:0] tin;
  logic          timeout;
  logic          expired;
  logic          busy;
  logic [TW-1:0] remaining;
`ifdef PHASE_TIMER_PAUSE_EN
  logic          pause;

  modport master (
    output present_state, tin, pause,
    input  timeout, expired, busy, remaining
  );

  modport slave (
    input  present_state, tin, pause,
    output timeout, expired, busy, remaining
  );
`else
  modport master (
    output present_state, tin,
    input  timeout, expired, busy, remaining
  );

  modport slave (
    input  present_state, tin,
    output timeout, expired, busy, remaining
  );
`endif
endinterface

// File: rtl/phase_timer.sv
// Phase interval timer: loads tin one cycle after a controller state change and counts it down.
// Optional PHASE_TIMER_PAUSE_EN adds a pause input that freezes counting in COUNT.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | untimed state or post-reset; waits for a state change
// LOAD     | one cycle after a change; samples tin from the selector
// COUNT    | prescaler running, cnt decrements once per PRESCALE cycles
// EXPIRED  | interval elapsed; expired held until the next state change
module phase_timer #(
  parameter int PRESCALE = 50000,
  parameter int TW       = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  phase_timer_if.slave  tif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_COUNT   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    prev_state_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          timeout_q, timeout_d;
  logic          expired_q, expired_d;
  logic          busy_q, busy_d;
  logic          change;
  logic          hold;

  assign change = (tif.present_state != prev_state_q);

`ifdef PHASE_TIMER_PAUSE_EN
  assign hold = tif.pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ps_d      = ps_q;
    timeout_d = 1'b0;
    expired_d = expired_q;

    // A state change outranks every other transition, including expiry.
    if (change) begin
      state_d   = ST_LOAD;
      ps_d      = '0;
      expired_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          ps_d = '0;
          if (tif.tin == '0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = tif.tin;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!hold) begin
            if (ps_q == PS_LAST) begin
              ps_d  = '0;
              cnt_d = cnt_q - 1'b1;
              if (cnt_q == TW'(1)) begin
                timeout_d = 1'b1;
                expired_d = 1'b1;
                state_d   = ST_EXPIRED;
              end
            end else begin
              ps_d = ps_q + 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          cnt_d     = '0;
          expired_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy_d = (state_d == ST_LOAD) || (state_d == ST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_state_q <= 4'b0000;
      cnt_q        <= '0;
      ps_q         <= '0;
      timeout_q    <= 1'b0;
      expired_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= tif.present_state;
      cnt_q        <= cnt_d;
      ps_q         <= ps_d;
      timeout_q    <= timeout_d;
      expired_q    <= expired_d;
      busy_q       <= busy_d;
    end
  end

  assign tif.timeout   = timeout_q;
  assign tif.expired   = expired_q;
  assign tif.busy      = busy_q;
  assign tif.remaining = cnt_q;

endmodule
